// File: rtl/acc_req_responder.sv
// acc_req_responder: accelerator-side endpoint of the CVA6 accelerator
// request/response interface. Committed requests are queued in a small FIFO
// and executed strictly one at a time in order: COMPUTE adds the operands
// after a fixed latency, LOAD/STORE go through a simple memory port, and
// anything else is answered as illegal. Responses carry the request tag.

// Protocol checker: memory responses are only meaningful while waiting on memory.
module acc_req_responder_chk (
    input logic clk_i,
    input logic rst_i,
    input logic mem_resp_valid_i,
    input logic in_mem_wait_i
);

    a_mem_resp_only_in_wait: assert property (
        @(posedge clk_i) disable iff (rst_i) mem_resp_valid_i |-> in_mem_wait_i
    );

endmodule

module acc_req_responder #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned ReqDepth      = 2,
    parameter int unsigned ExecLatency   = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [31:0]              req_insn_i,
    input  logic [XLEN-1:0]          req_rs1_i,
    input  logic [XLEN-1:0]          req_rs2_i,
    input  logic [TRANS_ID_BITS-1:0] req_trans_id_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [TRANS_ID_BITS-1:0] resp_trans_id_o,
    output logic [XLEN-1:0]          resp_result_o,
    output logic                     resp_error_o,
    output logic                     load_complete_o,
    output logic                     store_complete_o,
    output logic                     store_pending_o,
    output logic                     mem_req_valid_o,
    input  logic                     mem_req_ready_i,
    output logic                     mem_req_we_o,
    output logic [XLEN-1:0]          mem_req_addr_o,
    output logic [XLEN-1:0]          mem_req_wdata_o,
    input  logic                     mem_resp_valid_i,
    input  logic [XLEN-1:0]          mem_resp_rdata_i
);

    localparam int unsigned PTR_W = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
    localparam int unsigned CNT_W = $clog2(ReqDepth + 1);
    localparam int unsigned EXC_W = (ExecLatency > 1) ? $clog2(ExecLatency) : 1;
    localparam int unsigned SC_W  = $clog2(ReqDepth + 3);

    localparam logic [6:0] OP_COMPUTE = 7'h57;
    localparam logic [6:0] OP_LOAD    = 7'h07;
    localparam logic [6:0] OP_STORE   = 7'h27;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EXEC     = 3'd1,
        ST_MEM_REQ  = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        K_COMPUTE = 2'd0,
        K_LOAD    = 2'd1,
        K_STORE   = 2'd2,
        K_ILLEGAL = 2'd3
    } kind_t;

    // Map the major opcode onto the operation class this endpoint executes.
    function automatic kind_t decode_kind(input logic [6:0] op);
        kind_t k;
        case (op)
            OP_COMPUTE: k = K_COMPUTE;
            OP_LOAD:    k = K_LOAD;
            OP_STORE:   k = K_STORE;
            default:    k = K_ILLEGAL;
        endcase
        return k;
    endfunction

    // Even parity over the instruction bits above the opcode.
    function automatic logic insn_hi_parity(input logic [24:0] v);
        return ^v;
    endfunction

    // Only the opcode field selects behaviour; the remaining bits are folded
    // into a sink so the full instruction word stays on the port.
    logic unused_insn_hi_s;
    assign unused_insn_hi_s = insn_hi_parity(req_insn_i[31:7]);

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    kind_t                    fifo_kind_r [ReqDepth];
    logic [XLEN-1:0]          fifo_rs1_r  [ReqDepth];
    logic [XLEN-1:0]          fifo_rs2_r  [ReqDepth];
    logic [TRANS_ID_BITS-1:0] fifo_id_r   [ReqDepth];
    logic [PTR_W-1:0]         wr_ptr_r;
    logic [PTR_W-1:0]         rd_ptr_r;
    logic [PTR_W-1:0]         wr_ptr_inc_s;
    logic [PTR_W-1:0]         rd_ptr_inc_s;
    logic [CNT_W-1:0]         fifo_cnt_r;
    logic [CNT_W-1:0]         fifo_cnt_next_s;
    logic                     req_ready_r;
    logic                     push_s;
    logic                     pop_s;

    state_t                   state_r;
    state_t                   state_next_s;

    assign push_s = req_valid_i && req_ready_r;
    assign pop_s  = (state_r == ST_IDLE) && (fifo_cnt_r != {CNT_W{1'b0}});

    // Pointer wrap-around and occupancy update for the request FIFO.
    always_comb begin
        wr_ptr_inc_s    = wr_ptr_r;
        rd_ptr_inc_s    = rd_ptr_r;
        fifo_cnt_next_s = fifo_cnt_r;
        if (wr_ptr_r == PTR_W'(ReqDepth - 1)) begin
            wr_ptr_inc_s = {PTR_W{1'b0}};
        end else begin
            wr_ptr_inc_s = wr_ptr_r + PTR_W'(1);
        end
        if (rd_ptr_r == PTR_W'(ReqDepth - 1)) begin
            rd_ptr_inc_s = {PTR_W{1'b0}};
        end else begin
            rd_ptr_inc_s = rd_ptr_r + PTR_W'(1);
        end
        case ({push_s, pop_s})
            2'b10:   fifo_cnt_next_s = fifo_cnt_r + CNT_W'(1);
            2'b01:   fifo_cnt_next_s = fifo_cnt_r - CNT_W'(1);
            default: fifo_cnt_next_s = fifo_cnt_r;
        endcase
    end

    // FIFO storage, pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            fifo_cnt_r  <= {CNT_W{1'b0}};
            req_ready_r <= 1'b1;
            for (int i = 0; i < ReqDepth; i++) begin
                fifo_kind_r[i] <= K_ILLEGAL;
                fifo_rs1_r[i]  <= {XLEN{1'b0}};
                fifo_rs2_r[i]  <= {XLEN{1'b0}};
                fifo_id_r[i]   <= {TRANS_ID_BITS{1'b0}};
            end
        end else begin
            if (push_s) begin
                fifo_kind_r[wr_ptr_r] <= decode_kind(req_insn_i[6:0]);
                fifo_rs1_r[wr_ptr_r]  <= req_rs1_i;
                fifo_rs2_r[wr_ptr_r]  <= req_rs2_i;
                fifo_id_r[wr_ptr_r]   <= req_trans_id_i;
                wr_ptr_r              <= wr_ptr_inc_s;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_inc_s;
            end
            fifo_cnt_r  <= fifo_cnt_next_s;
            // No pop bypass: ready reflects only whether the FIFO will be full.
            req_ready_r <= (fifo_cnt_next_s != CNT_W'(ReqDepth));
        end
    end

    // ------------------------------------------------------------------
    // Execution FSM and working registers
    // ------------------------------------------------------------------
    kind_t                    kind_r,          kind_next_s;
    logic [XLEN-1:0]          rs1_r,           rs1_next_s;
    logic [XLEN-1:0]          rs2_r,           rs2_next_s;
    logic [TRANS_ID_BITS-1:0] id_r,            id_next_s;
    logic [EXC_W-1:0]         exec_cnt_r,      exec_cnt_next_s;
    logic [XLEN-1:0]          result_r,        result_next_s;
    logic                     error_r,         error_next_s;
    logic                     mem_we_r,        mem_we_next_s;
    logic                     mem_req_valid_r, mem_req_valid_next_s;
    logic                     resp_valid_r,    resp_valid_next_s;
    logic                     load_cpl_r,      load_cpl_next_s;
    logic                     store_cpl_r,     store_cpl_next_s;

    // Next-state and next-output decode for the single in-flight instruction.
    always_comb begin
        state_next_s     = state_r;
        kind_next_s      = kind_r;
        rs1_next_s       = rs1_r;
        rs2_next_s       = rs2_r;
        id_next_s        = id_r;
        exec_cnt_next_s  = exec_cnt_r;
        result_next_s    = result_r;
        error_next_s     = error_r;
        mem_we_next_s    = mem_we_r;
        load_cpl_next_s  = 1'b0;
        store_cpl_next_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    kind_next_s   = fifo_kind_r[rd_ptr_r];
                    rs1_next_s    = fifo_rs1_r[rd_ptr_r];
                    rs2_next_s    = fifo_rs2_r[rd_ptr_r];
                    id_next_s     = fifo_id_r[rd_ptr_r];
                    result_next_s = {XLEN{1'b0}};
                    error_next_s  = 1'b0;
                    mem_we_next_s = (fifo_kind_r[rd_ptr_r] == K_STORE);
                    case (fifo_kind_r[rd_ptr_r])
                        K_COMPUTE: begin
                            state_next_s    = ST_EXEC;
                            exec_cnt_next_s = EXC_W'(ExecLatency - 1);
                        end
                        K_LOAD:  state_next_s = ST_MEM_REQ;
                        K_STORE: state_next_s = ST_MEM_REQ;
                        default: begin
                            state_next_s = ST_RESP;
                            error_next_s = 1'b1;
                        end
                    endcase
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (exec_cnt_r == {EXC_W{1'b0}}) begin
                    result_next_s = rs1_r + rs2_r;
                    state_next_s  = ST_RESP;
                end else begin
                    exec_cnt_next_s = exec_cnt_r - EXC_W'(1);
                end
            end
            ST_MEM_REQ: begin
                if (mem_req_ready_i) begin
                    state_next_s = ST_MEM_WAIT;
                end else begin
                    state_next_s = ST_MEM_REQ;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_resp_valid_i) begin
                    if (kind_r == K_LOAD) begin
                        result_next_s   = mem_resp_rdata_i;
                        load_cpl_next_s = 1'b1;
                    end else begin
                        result_next_s    = {XLEN{1'b0}};
                        store_cpl_next_s = 1'b1;
                    end
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_MEM_WAIT;
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        mem_req_valid_next_s = (state_next_s == ST_MEM_REQ);
        resp_valid_next_s    = (state_next_s == ST_RESP);
    end

    // State, working registers and registered interface outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r         <= ST_IDLE;
            kind_r          <= K_ILLEGAL;
            rs1_r           <= {XLEN{1'b0}};
            rs2_r           <= {XLEN{1'b0}};
            id_r            <= {TRANS_ID_BITS{1'b0}};
            exec_cnt_r      <= {EXC_W{1'b0}};
            result_r        <= {XLEN{1'b0}};
            error_r         <= 1'b0;
            mem_we_r        <= 1'b0;
            mem_req_valid_r <= 1'b0;
            resp_valid_r    <= 1'b0;
            load_cpl_r      <= 1'b0;
            store_cpl_r     <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            kind_r          <= kind_next_s;
            rs1_r           <= rs1_next_s;
            rs2_r           <= rs2_next_s;
            id_r            <= id_next_s;
            exec_cnt_r      <= exec_cnt_next_s;
            result_r        <= result_next_s;
            error_r         <= error_next_s;
            mem_we_r        <= mem_we_next_s;
            mem_req_valid_r <= mem_req_valid_next_s;
            resp_valid_r    <= resp_valid_next_s;
            load_cpl_r      <= load_cpl_next_s;
            store_cpl_r     <= store_cpl_next_s;
        end
    end

    // ------------------------------------------------------------------
    // Outstanding-store counter
    // ------------------------------------------------------------------
    logic [SC_W-1:0] store_cnt_r;
    logic [SC_W-1:0] store_cnt_next_s;
    logic            store_pending_r;
    logic            store_accept_s;

    assign store_accept_s = push_s && (req_insn_i[6:0] == OP_STORE);

    // Count accepted stores up and completed stores down.
    always_comb begin
        store_cnt_next_s = store_cnt_r;
        case ({store_accept_s, store_cpl_r})
            2'b10:   store_cnt_next_s = store_cnt_r + SC_W'(1);
            2'b01:   store_cnt_next_s = store_cnt_r - SC_W'(1);
            default: store_cnt_next_s = store_cnt_r;
        endcase
    end

    // Counter register and its registered non-zero flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            store_cnt_r     <= {SC_W{1'b0}};
            store_pending_r <= 1'b0;
        end else begin
            store_cnt_r     <= store_cnt_next_s;
            store_pending_r <= (store_cnt_next_s != {SC_W{1'b0}});
        end
    end

    assign req_ready_o      = req_ready_r;
    assign resp_valid_o     = resp_valid_r;
    assign resp_trans_id_o  = id_r;
    assign resp_result_o    = result_r;
    assign resp_error_o     = error_r;
    assign load_complete_o  = load_cpl_r;
    assign store_complete_o = store_cpl_r;
    assign store_pending_o  = store_pending_r;
    assign mem_req_valid_o  = mem_req_valid_r;
    assign mem_req_we_o     = mem_we_r;
    assign mem_req_addr_o   = rs1_r;
    assign mem_req_wdata_o  = rs2_r;

    logic in_mem_wait_s;
    assign in_mem_wait_s = (state_r == ST_MEM_WAIT);

    acc_req_responder_chk u_chk (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .mem_resp_valid_i (mem_resp_valid_i),
        .in_mem_wait_i    (in_mem_wait_s)
    );

endmodule

// File: tb/tb_acc_req_responder.sv
// Directed bench for acc_req_responder (XLEN=64, ReqDepth=2, ExecLatency=3).
// Inputs change and outputs are sampled at the falling clock edge.
module tb_acc_req_responder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_insn_i;
    logic [63:0] req_rs1_i;
    logic [63:0] req_rs2_i;
    logic [2:0]  req_trans_id_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [2:0]  resp_trans_id_o;
    logic [63:0] resp_result_o;
    logic        resp_error_o;
    logic        load_complete_o;
    logic        store_complete_o;
    logic        store_pending_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic        mem_req_we_o;
    logic [63:0] mem_req_addr_o;
    logic [63:0] mem_req_wdata_o;
    logic        mem_resp_valid_i;
    logic [63:0] mem_resp_rdata_i;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    acc_req_responder #(
        .XLEN(64), .TRANS_ID_BITS(3), .ReqDepth(2), .ExecLatency(3)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_insn_i       (req_insn_i),
        .req_rs1_i        (req_rs1_i),
        .req_rs2_i        (req_rs2_i),
        .req_trans_id_i   (req_trans_id_i),
        .resp_valid_o     (resp_valid_o),
        .resp_ready_i     (resp_ready_i),
        .resp_trans_id_o  (resp_trans_id_o),
        .resp_result_o    (resp_result_o),
        .resp_error_o     (resp_error_o),
        .load_complete_o  (load_complete_o),
        .store_complete_o (store_complete_o),
        .store_pending_o  (store_pending_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_we_o     (mem_req_we_o),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_req_wdata_o  (mem_req_wdata_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_rdata_i (mem_resp_rdata_i)
    );

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        req_valid_i      = 1'b0;
        req_insn_i       = 32'h0;
        req_rs1_i        = 64'h0;
        req_rs2_i        = 64'h0;
        req_trans_id_i   = 3'd0;
        resp_ready_i     = 1'b0;
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_rdata_i = 64'h0;
    endtask

    task automatic drive_req(input logic [31:0] insn, input logic [63:0] a,
                             input logic [63:0] b, input logic [2:0] id);
        req_valid_i    = 1'b1;
        req_insn_i     = insn;
        req_rs1_i      = a;
        req_rs2_i      = b;
        req_trans_id_i = id;
    endtask

    task automatic wait_resp(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            if (resp_valid_o === 1'b1) seen = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b1;
        repeat (2) tick();
        n_vec++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %0h expected 1", req_ready_o); end
        n_vec++; if (resp_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %0h expected 0", resp_valid_o); end
        n_vec++; if (resp_result_o !== 64'h0) begin n_err++; $display("FAIL rst_result: got %0h expected 0", resp_result_o); end
        n_vec++; if (mem_req_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_mem_valid: got %0h expected 0", mem_req_valid_o); end
        n_vec++; if (store_pending_o !== 1'b0) begin n_err++; $display("FAIL rst_pending: got %0h expected 0", store_pending_o); end
        n_vec++; if ({load_complete_o, store_complete_o} !== 2'b00) begin n_err++; $display("FAIL rst_complete: got %0h expected 0", {load_complete_o, store_complete_o}); end
        rst_i = 1'b0;
        tick();
        n_vec++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_rel_ready: got %0h expected 1", req_ready_o); end
    endtask

    task automatic test_compute();
        resp_ready_i = 1'b1;
        drive_req(32'h0000_0057, 64'd5, 64'd7, 3'd2);          // cycle 0
        n_vec++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL cmp_ready: got %0h expected 1", req_ready_o); end
        tick();
        req_valid_i = 1'b0;                                    // cycle 1
        for (int c = 1; c < 5; c++) begin
            n_vec++; if (resp_valid_o !== 1'b0) begin n_err++; $display("FAIL cmp_early_c%0d: got %0h expected 0", c, resp_valid_o); end
            tick();
        end
        // cycle 5 = 2 + ExecLatency
        n_vec++; if (resp_valid_o !== 1'b1) begin n_err++; $display("FAIL cmp_valid: got %0h expected 1", resp_valid_o); end
        n_vec++; if (resp_trans_id_o !== 3'd2) begin n_err++; $display("FAIL cmp_id: got %0h expected 2", resp_trans_id_o); end
        n_vec++; if (resp_result_o !== 64'd12) begin n_err++; $display("FAIL cmp_result: got %0h expected c", resp_result_o); end
        n_vec++; if (resp_error_o !== 1'b0) begin n_err++; $display("FAIL cmp_error: got %0h expected 0", resp_error_o); end
        tick();
        n_vec++; if (resp_valid_o !== 1'b0) begin n_err++; $display("FAIL cmp_drop: got %0h expected 0", resp_valid_o); end
        tick();
    endtask

    task automatic test_compute_wrap();
        bit seen;
        resp_ready_i = 1'b1;
        drive_req(32'h0000_0057, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd5);
        tick();
        req_valid_i = 1'b0;
        wait_resp(20, seen);
        n_vec++; if (!seen) begin n_err++; $display("FAIL wrap_timeout: got no response expected one"); end
        n_vec++; if (resp_result_o !== 64'h0) begin n_err++; $display("FAIL wrap_result: got %0h expected 0", resp_result_o); end
        n_vec++; if (resp_trans_id_o !== 3'd5) begin n_err++; $display("FAIL wrap_id: got %0h expected 5", resp_trans_id_o); end
        tick();
        tick();
    endtask

    task automatic test_store();
        resp_ready_i    = 1'b1;
        mem_req_ready_i = 1'b0;
        drive_req(32'h0000_0027, 64'h1000, 64'hAB, 3'd3);      // cycle 0
        n_vec++; if (store_pending_o !== 1'b0) begin n_err++; $display("FAIL st_pend_c0: got %0h expected 0", store_pending_o); end
        tick();
        req_valid_i = 1'b0;                                    // cycle 1
        n_vec++; if (store_pending_o !== 1'b1) begin n_err++; $display("FAIL st_pend_c1: got %0h expected 1", store_pending_o); end
        tick();                                                // cycle 2
        for (int c = 2; c < 5; c++) begin
            n_vec++; if (mem_req_valid_o !== 1'b1) begin n_err++; $display("FAIL st_mvalid_c%0d: got %0h expected 1", c, mem_req_valid_o); end
            n_vec++; if (mem_req_addr_o !== 64'h1000) begin n_err++; $display("FAIL st_addr_c%0d: got %0h expected 1000", c, mem_req_addr_o); end
            n_vec++; if (mem_req_wdata_o !== 64'hAB) begin n_err++; $display("FAIL st_wdata_c%0d: got %0h expected ab", c, mem_req_wdata_o); end
            n_vec++; if (mem_req_we_o !== 1'b1) begin n_err++; $display("FAIL st_we_c%0d: got %0h expected 1", c, mem_req_we_o); end
            if (c == 4) mem_req_ready_i = 1'b1;                 // accepted two cycles late
            tick();
        end
        mem_req_ready_i  = 1'b0;                               // cycle 5: MEM_WAIT
        n_vec++; if (mem_req_valid_o !== 1'b0) begin n_err++; $display("FAIL st_mvalid_drop: got %0h expected 0", mem_req_valid_o); end
        mem_resp_valid_i = 1'b1;
        tick();
        mem_resp_valid_i = 1'b0;                               // cycle 6: RESP
        n_vec++; if (store_complete_o !== 1'b1) begin n_err++; $display("FAIL st_cpl: got %0h expected 1", store_complete_o); end
        n_vec++; if (resp_valid_o !== 1'b1) begin n_err++; $display("FAIL st_resp: got %0h expected 1", resp_valid_o); end
        n_vec++; if (resp_result_o !== 64'h0) begin n_err++; $display("FAIL st_result: got %0h expected 0", resp_result_o); end
        n_vec++; if (resp_trans_id_o !== 3'd3) begin n_err++; $display("FAIL st_id: got %0h expected 3", resp_trans_id_o); end
        n_vec++; if (store_pending_o !== 1'b1) begin n_err++; $display("FAIL st_pend_c6: got %0h expected 1", store_pending_o); end
        tick();                                                // cycle 7
        n_vec++; if (store_complete_o !== 1'b0) begin n_err++; $display("FAIL st_cpl_once: got %0h expected 0", store_complete_o); end
        n_vec++; if (store_pending_o !== 1'b0) begin n_err++; $display("FAIL st_pend_clear: got %0h expected 0", store_pending_o); end
        tick();
    endtask

    task automatic test_load();
        resp_ready_i    = 1'b0;
        mem_req_ready_i = 1'b1;
        drive_req(32'h0000_0007, 64'h2000, 64'h0, 3'd4);       // cycle 0
        tick();
        req_valid_i = 1'b0;                                    // cycle 1
        tick();                                                // cycle 2: MEM_REQ accepted
        n_vec++; if (mem_req_we_o !== 1'b0) begin n_err++; $display("FAIL ld_we: got %0h expected 0", mem_req_we_o); end
        tick();                                                // cycle 3: MEM_WAIT
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b1;
        mem_resp_rdata_i = 64'hDEAD;
        tick();                                                // cycle 4: RESP
        mem_resp_valid_i = 1'b0;
        mem_resp_rdata_i = 64'h0;
        n_vec++; if (load_complete_o !== 1'b1) begin n_err++; $display("FAIL ld_cpl: got %0h expected 1", load_complete_o); end
        n_vec++; if (resp_result_o !== 64'hDEAD) begin n_err++; $display("FAIL ld_result: got %0h expected dead", resp_result_o); end
        n_vec++; if (resp_trans_id_o !== 3'd4) begin n_err++; $display("FAIL ld_id: got %0h expected 4", resp_trans_id_o); end
        n_vec++; if (store_pending_o !== 1'b0) begin n_err++; $display("FAIL ld_pend: got %0h expected 0", store_pending_o); end
        tick();                                                // cycle 5: held by backpressure
        n_vec++; if (load_complete_o !== 1'b0) begin n_err++; $display("FAIL ld_cpl_once: got %0h expected 0", load_complete_o); end
        n_vec++; if (resp_valid_o !== 1'b1) begin n_err++; $display("FAIL ld_hold_valid: got %0h expected 1", resp_valid_o); end
        n_vec++; if (resp_result_o !== 64'hDEAD) begin n_err++; $display("FAIL ld_hold_result: got %0h expected dead", resp_result_o); end
        resp_ready_i = 1'b1;
        tick();
        n_vec++; if (resp_valid_o !== 1'b0) begin n_err++; $display("FAIL ld_drop: got %0h expected 0", resp_valid_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0]  exp_id  [3];
        logic [63:0] exp_res [3];
        logic        exp_err [3];
        int          got;
        exp_id[0] = 3'd0; exp_res[0] = 64'd3;  exp_err[0] = 1'b0;
        exp_id[1] = 3'd1; exp_res[1] = 64'd30; exp_err[1] = 1'b0;
        exp_id[2] = 3'd2; exp_res[2] = 64'd0;  exp_err[2] = 1'b1;
        resp_ready_i = 1'b0;
        drive_req(32'h0000_0057, 64'd1, 64'd2, 3'd0);          // cycle 0
        tick();
        drive_req(32'h0000_0057, 64'd10, 64'd20, 3'd1);        // cycle 1
        n_vec++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_ready_c1: got %0h expected 1", req_ready_o); end
        tick();
        drive_req(32'h0000_0033, 64'd9, 64'd9, 3'd2);          // cycle 2
        n_vec++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_ready_c2: got %0h expected 1", req_ready_o); end
        tick();
        req_valid_i = 1'b0;                                    // cycle 3: FIFO holds B and C
        n_vec++; if (req_ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_full: got %0h expected 0", req_ready_o); end
        repeat (6) tick();                                     // cycle 9
        n_vec++; if (resp_valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_hold_valid: got %0h expected 1", resp_valid_o); end
        n_vec++; if (resp_trans_id_o !== 3'd0) begin n_err++; $display("FAIL b2b_hold_id: got %0h expected 0", resp_trans_id_o); end
        n_vec++; if (req_ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_still_full: got %0h expected 0", req_ready_o); end
        tick();                                                // cycle 10
        resp_ready_i = 1'b1;
        got = 0;
        for (int i = 0; i < 40 && got < 3; i++) begin
            if (resp_valid_o === 1'b1) begin
                n_vec++; if (resp_trans_id_o !== exp_id[got]) begin n_err++; $display("FAIL b2b_id%0d: got %0h expected %0h", got, resp_trans_id_o, exp_id[got]); end
                n_vec++; if (resp_result_o !== exp_res[got]) begin n_err++; $display("FAIL b2b_res%0d: got %0h expected %0h", got, resp_result_o, exp_res[got]); end
                n_vec++; if (resp_error_o !== exp_err[got]) begin n_err++; $display("FAIL b2b_err%0d: got %0h expected %0h", got, resp_error_o, exp_err[got]); end
                got++;
            end
            tick();
        end
        n_vec++; if (got != 3) begin n_err++; $display("FAIL b2b_count: got %0d expected 3", got); end
        resp_ready_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_exec();
        bit seen;
        resp_ready_i = 1'b1;
        drive_req(32'h0000_0057, 64'd4, 64'd4, 3'd1);          // cycle 0
        tick();
        drive_req(32'h0000_0027, 64'h3000, 64'h55, 3'd2);      // cycle 1: store queued behind
        tick();
        req_valid_i = 1'b0;                                    // cycle 2
        tick();                                                // cycle 3: mid-EXEC
        n_vec++; if (store_pending_o !== 1'b1) begin n_err++; $display("FAIL mid_pend_pre: got %0h expected 1", store_pending_o); end
        #2 rst_i = 1'b1;
        #1;
        n_vec++; if (resp_valid_o !== 1'b0) begin n_err++; $display("FAIL mid_resp_valid: got %0h expected 0", resp_valid_o); end
        n_vec++; if (mem_req_valid_o !== 1'b0) begin n_err++; $display("FAIL mid_mem_valid: got %0h expected 0", mem_req_valid_o); end
        n_vec++; if (store_pending_o !== 1'b0) begin n_err++; $display("FAIL mid_pend: got %0h expected 0", store_pending_o); end
        tick();
        rst_i = 1'b0;
        tick();
        n_vec++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL mid_ready: got %0h expected 1", req_ready_o); end
        for (int c = 0; c < 8; c++) begin
            n_vec++; if ({resp_valid_o, mem_req_valid_o, store_complete_o} !== 3'b000) begin n_err++; $display("FAIL mid_quiet_c%0d: got %0h expected 0", c, {resp_valid_o, mem_req_valid_o, store_complete_o}); end
            tick();
        end
        drive_req(32'h0000_0057, 64'd100, 64'd23, 3'd6);
        tick();
        req_valid_i = 1'b0;
        wait_resp(20, seen);
        n_vec++; if (!seen) begin n_err++; $display("FAIL mid_after_timeout: got no response expected one"); end
        n_vec++; if (resp_result_o !== 64'd123) begin n_err++; $display("FAIL mid_after_result: got %0h expected 7b", resp_result_o); end
        tick();
    endtask

    initial begin
        idle_inputs();
        rst_i = 1'b1;
        test_reset();
        test_compute();
        test_compute_wrap();
        test_store();
        test_load();
        test_back_to_back();
        test_reset_mid_exec();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
